// File: rtl/text_scan_gen_if.sv
// Bus bundle between the text-mode scan generator, its text RAM and the ROM stage.
// master: scan generator (drives RAM address and pixel-stage outputs); slave: RAM/ROM side.
// Macro TEXT_CURSOR_EN adds cursor_x/cursor_y (to master) and cursor_on (from master).
interface text_scan_gen_if;
    logic [11:0] vram_addr;
    logic [7:0]  vram_data;
    logic [7:0]  chr_val;
    logic [2:0]  col;
    logic [3:0]  row;
    logic        hsync;
    logic        vsync;
    logic        blank;
    logic        frame_start;
`ifdef TEXT_CURSOR_EN
    logic [6:0]  cursor_x;
    logic [4:0]  cursor_y;
    logic        cursor_on;

    modport master (
        output vram_addr, input vram_data,
        output chr_val, output col, output row,
        output hsync, output vsync, output blank, output frame_start,
        input  cursor_x, input cursor_y, output cursor_on
    );
    modport slave (
        input  vram_addr, output vram_data,
        input  chr_val, input col, input row,
        input  hsync, input vsync, input blank, input frame_start,
        output cursor_x, output cursor_y, input cursor_on
    );
`else
    modport master (
        output vram_addr, input vram_data,
        output chr_val, output col, output row,
        output hsync, output vsync, output blank, output frame_start
    );
    modport slave (
        input  vram_addr, output vram_data,
        input  chr_val, input col, input row,
        input  hsync, input vsync, input blank, input frame_start
    );
`endif
endinterface

// File: rtl/text_scan_gen.sv
// VGA text-mode scan generator: 640x480@60 timing, 80x30 cell walk, text RAM fetch for the ROM stage.
// Latency: vram_addr 1 cycle, chr_val/col/row 2 cycles, hsync/vsync/blank(/cursor_on) 3 cycles after the counters.
// No backpressure: free-running at the pixel clock; the RAM must return data one cycle after the address.
// Ports: clk, rst_n (async active-low), bus (text_scan_gen_if.master: vram_addr/vram_data, chr_val, col, row,
//        hsync, vsync, blank, frame_start). Optional macro TEXT_CURSOR_EN adds cursor_x, cursor_y, cursor_on.
module text_scan_gen #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int COLS   = 80
) (
    input  logic            clk,
    input  logic            rst_n,
    text_scan_gen_if.master bus
);
    localparam int H_TOT = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_VIS + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST  = 10'(H_TOT - 1);
    localparam logic [9:0] V_LAST  = 10'(V_TOT - 1);
    localparam logic [9:0] H_VIS_W = 10'(H_VIS);
    localparam logic [9:0] V_VIS_W = 10'(V_VIS);
    localparam logic [9:0] HS_LO   = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_HI   = 10'(H_VIS + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_LO   = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_HI   = 10'(V_VIS + V_FP + V_SYNC - 1);

    // Stage 0: raster counters
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    logic        vis0;
    logic        hs0;
    logic        vs0;
    logic [5:0]  cell_row;
    logic [6:0]  cell_col;
    logic [11:0] row_base;
    logic [11:0] addr0;

    assign vis0     = (h_cnt < H_VIS_W) && (v_cnt < V_VIS_W);
    assign hs0      = !((h_cnt >= HS_LO) && (h_cnt <= HS_HI));
    assign vs0      = !((v_cnt >= VS_LO) && (v_cnt <= VS_HI));
    assign cell_row = v_cnt[9:4];
    assign cell_col = h_cnt[9:3];

    // Row base = cell_row * COLS; the 80-column case is a shift-add (64 + 16).
    generate
        if (COLS == 80) begin : g_mul80
            assign row_base = ({6'd0, cell_row} << 6) + ({6'd0, cell_row} << 4);
        end else begin : g_mul
            assign row_base = {6'd0, cell_row} * 12'(COLS);
        end
    endgenerate

    assign addr0 = row_base + {5'd0, cell_col};

    // Stage 1..3 delay lines. Sync/blank reset to their inactive (high) levels
    // so nothing spurious reaches the monitor while the pipe refills.
    logic [11:0] vram_addr_q;
    logic        frame_start_q;
    logic        vis1, vis2;
    logic [2:0]  col1, col2;
    logic [3:0]  row1, row2;
    logic        hs1, hs2, hs3;
    logic        vs1, vs2, vs3;
    logic        blank3;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vram_addr_q   <= '0;
            frame_start_q <= 1'b0;
            vis1          <= 1'b0;
            vis2          <= 1'b0;
            col1          <= '0;
            col2          <= '0;
            row1          <= '0;
            row2          <= '0;
            hs1           <= 1'b1;
            hs2           <= 1'b1;
            hs3           <= 1'b1;
            vs1           <= 1'b1;
            vs2           <= 1'b1;
            vs3           <= 1'b1;
            blank3        <= 1'b1;
        end else begin
            // Porch cycles park the address at 0 so it never leaves 0..2399.
            vram_addr_q   <= vis0 ? addr0 : 12'd0;
            frame_start_q <= (h_cnt == 10'd0) && (v_cnt == 10'd0);
            vis1          <= vis0;
            col1          <= h_cnt[2:0];
            row1          <= v_cnt[3:0];
            hs1           <= hs0;
            vs1           <= vs0;
            vis2          <= vis1;
            col2          <= col1;
            row2          <= row1;
            hs2           <= hs1;
            vs2           <= vs1;
            blank3        <= !vis2;
            hs3           <= hs2;
            vs3           <= vs2;
        end
    end

    assign bus.vram_addr   = vram_addr_q;
    assign bus.frame_start = frame_start_q;
    // RAM data lands in stage 2; outside the visible area force a space so
    // the ROM address (chr_val-32)<<4 stays in range.
    assign bus.chr_val     = vis2 ? bus.vram_data : 8'h20;
    assign bus.col         = col2;
    assign bus.row         = row2;
    assign bus.hsync       = hs3;
    assign bus.vsync       = vs3;
    assign bus.blank       = blank3;

`ifdef TEXT_CURSOR_EN
    // Cursor: underline on the bottom two pixel rows of the selected cell,
    // blinking with bit 4 of a frame counter (16 frames on, 16 off).
    logic [4:0] frame_cnt;
    logic       cur0, cur1, cur2, cur3;

    assign cur0 = vis0 && (cell_col == bus.cursor_x) && (cell_row == {1'b0, bus.cursor_y})
                  && (v_cnt[3:0] >= 4'd14);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            cur1      <= 1'b0;
            cur2      <= 1'b0;
            cur3      <= 1'b0;
        end else begin
            if (frame_start_q) begin
                frame_cnt <= frame_cnt + 5'd1;
            end
            cur1 <= cur0;
            cur2 <= cur1;
            cur3 <= cur2 && frame_cnt[4];
        end
    end

    assign bus.cursor_on = cur3;
`endif

endmodule
